test_i1914_capture: RTL and testbench
=====================================

# test_i1914_capture

Serial capture and pattern-monitor stage that sits directly downstream of the registered single-bit output I1914. It deserialises the I1914 bit stream into W-bit words and hands them out over a valid/ready handshake. It also watches a sliding W-bit window for a trigger pattern and raises a sticky alarm after a programmable number of hits. The serial input cannot be back-pressured, so word loss is flagged rather than stalled.

## Interface
- W, 8, word and window width (W ≥ 2)
- PATTERN, 8'hA5, W-bit trigger pattern compared against the sliding window
- MATCH_LIMIT, 3, match count at which alarm asserts (1 ≤ MATCH_LIMIT ≤ 15)

Ports:
- I1294  in  1  clock, rising edge
- I1300  in  1  reset, asynchronous, active-low
- I1914  in  1  serial data bit from upstream stage
- bit_en  in  1  sample enable; I1914 is taken only on edges where bit_en=1
- clr  in  1  synchronous clear of monitor state (see Operation)
- word_out  out  W  captured word, MSB = earliest bit
- word_valid  out  1  word_out holds an untaken word
- word_ready  in  1  consumer accepts word_out when word_valid=1
- match  out  1  one-cycle pulse per window hit
- match_cnt  out  4  saturating hit counter
- alarm  out  1  sticky, set when match_cnt reaches MATCH_LIMIT
- overflow  out  1  sticky, a completed word was dropped

## Operation
- Shift register sr[W-1:0]: on an edge with bit_en=1, sr <= {sr[W-2:0], I1914}.
- Bit counter bcnt, range 0..W-1: increments on each bit_en edge and wraps W-1 -> 0. An edge with bcnt=W-1 and bit_en=1 completes a word equal to the post-shift sr.
- Holding register:
  - Word complete with word_valid=0, or with word_valid=1 and word_ready=1 on the same edge: load word_out, and word_valid is 1 afterwards. Load wins over take.
  - Word complete with word_valid=1 and word_ready=0: new word dropped, word_out unchanged, overflow <= 1.
  - word_valid=1 and word_ready=1 with no completion: word_valid <= 0. word_out holds its value.
- Monitor FSM, all transitions on bit_en edges unless noted:
  - IDLE: no bits since reset/clr. First bit_en edge -> FILL; fill count = 1.
  - FILL: fewer than W bits seen. Move to ARMED on the edge that brings fill count to W; the window is compared on that same edge.
  - ARMED: on each bit_en edge, if the post-shift sr equals PATTERN, pulse match and increment match_cnt (saturates at 15). On the edge match_cnt becomes MATCH_LIMIT -> ALARM and alarm <= 1.
  - ALARM: alarm stays 1. Matching, counting and capture continue.
- clr=1 (takes priority over bit_en on the same edge):
  - FSM -> IDLE; fill count, bcnt, match_cnt, match, alarm and overflow go to 0; sr goes to 0.
  - word_out and word_valid are unaffected, and a take on the same edge still completes.
- bit_en=0: sr, bcnt, fill count and FSM hold; match is 0.

## Timing
- All outputs registered. Reset values: word_out=0, word_valid=0, match=0, match_cnt=0, alarm=0, overflow=0, FSM=IDLE, sr=0, bcnt=0.
- Capture latency: word_valid rises in the cycle after the edge that samples the W-th bit.
- match is high for exactly the one cycle after the matching bit_en edge. alarm rises in the same cycle as the match that reaches MATCH_LIMIT.
- Overlapping patterns each count. With PATTERN=8'hAA, the stream A,A,A,A,A... matches every second bit.
- Reset asserted mid-word or mid-handshake clears everything immediately. The partial word is discarded, and no word_valid appears after release until W fresh bits are received.
- Sustained rate: one bit per cycle indefinitely. With word_ready tied high, no overflow ever occurs.

## Test plan
- Reset, then 16 bits 1010_0101 1100_0011 with bit_en=1 and word_ready=1 -> word_out 8'hA5 with word_valid after bit 8, then 8'hC3 after bit 16; match pulses once after bit 8; match_cnt=1.
- word_ready=0 while 24 bits stream -> first word held, overflow=1 after bit 16, word_out still the first word; raise word_ready -> word_valid drops next cycle.
- Word completes on the same edge as a take -> word_out updates, word_valid stays 1 with no gap, and overflow stays 0.
- Feed A5 three times, then A5 a fourth time (MATCH_LIMIT=3) -> alarm rises in the cycle after the 24th bit, match_cnt=3 then 4, and alarm remains 1.
- clr pulse while in ALARM with word_valid=1 -> alarm, match_cnt and overflow are 0 next cycle; word_valid and word_out retained; the next match requires 8 new bits.
- Assert I1300 low after 5 bits, release, send 8 bits 0xA5 -> exactly one word 8'hA5 and one match; no residue from the pre-reset bits.

Source files
------------

// File: rtl/test_i1914_capture.sv
// -----------------------------------------------------------------------------
// test_i1914_capture
//
// Serial capture and pattern monitor for the single-bit I1914 stream.
// Incoming bits are shifted into a W-bit register. Every W sampled bits form
// one word, which is presented on a valid/ready holding register. The serial
// side cannot be stalled, so a word that completes while the holding register
// is still full is dropped, and the sticky overflow flag is set.
// In parallel, the sliding W-bit window is compared against PATTERN once W bits
// have been seen. The hits are counted, and a sticky alarm is raised when the
// count reaches MATCH_LIMIT.
//
// Ports
//   I1294      in   clock, rising edge
//   I1300      in   asynchronous active-low reset
//   I1914      in   serial data bit
//   bit_en     in   sample enable for I1914
//   clr        in   synchronous clear of the monitor / serial state
//   word_out   out  captured word, MSB = earliest bit
//   word_valid out  word_out holds an untaken word
//   word_ready in   consumer takes word_out when word_valid=1
//   match      out  one-cycle pulse per window hit
//   match_cnt  out  saturating hit counter
//   alarm      out  sticky, match_cnt reached MATCH_LIMIT
//   overflow   out  sticky, a completed word was dropped
// -----------------------------------------------------------------------------
module test_i1914_capture #(
    parameter int          W           = 8,
    parameter logic [W-1:0] PATTERN    = 8'hA5,
    parameter int          MATCH_LIMIT = 3
) (
    input  logic         I1294,
    input  logic         I1300,
    input  logic         I1914,
    input  logic         bit_en,
    input  logic         clr,
    output logic [W-1:0] word_out,
    output logic         word_valid,
    input  logic         word_ready,
    output logic         match,
    output logic [3:0]   match_cnt,
    output logic         alarm,
    output logic         overflow
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam int FW = $clog2(W + 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(W - 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(W - 1);
    localparam logic [3:0]    LIMIT     = 4'(MATCH_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2,
        ALARM = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    sr;
    logic [W-1:0]    sr_next;
    logic [BW-1:0]   bcnt;
    logic [FW-1:0]   fill_q, fill_d;
    logic [3:0]      cnt_d;
    logic            hit;
    logic            alarm_set;
    logic            word_done;

    assign sr_next   = {sr[W-2:0], I1914};
    // clr outranks bit_en, so a clear edge never completes a word
    assign word_done = bit_en && !clr && (bcnt == BCNT_LAST);

    // Monitor next-state: window compare starts on the edge that fills the window
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        cnt_d     = match_cnt;
        hit       = 1'b0;
        alarm_set = 1'b0;
        if (clr) begin
            state_d = IDLE;
            fill_d  = '0;
            cnt_d   = '0;
        end else if (bit_en) begin
            case (state_q)
                IDLE: begin
                    state_d = FILL;
                    fill_d  = FW'(1);
                end
                FILL: begin
                    fill_d = fill_q + FW'(1);
                    if (fill_q == FILL_LAST) begin
                        state_d = ARMED;
                        hit     = (sr_next == PATTERN);
                    end
                end
                ARMED, ALARM: begin
                    hit = (sr_next == PATTERN);
                end
                default: state_d = IDLE;
            endcase
            if (hit) begin
                if (match_cnt != 4'd15) begin
                    cnt_d = match_cnt + 4'd1;
                end
                // only the edge on which the count first reaches the limit
                if (cnt_d == LIMIT && match_cnt != LIMIT) begin
                    state_d   = ALARM;
                    alarm_set = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge I1294 or negedge I1300) begin
        if (!I1300) begin
            state_q   <= IDLE;
            fill_q    <= '0;
            match_cnt <= '0;
            match     <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            match_cnt <= cnt_d;
            match     <= hit;
            if (clr) begin
                alarm <= 1'b0;
            end else if (alarm_set) begin
                alarm <= 1'b1;
            end
        end
    end

    // Serial shift register and bit counter
    always_ff @(posedge I1294 or negedge I1300) begin
        if (!I1300) begin
            sr   <= '0;
            bcnt <= '0;
        end else if (clr) begin
            sr   <= '0;
            bcnt <= '0;
        end else if (bit_en) begin
            sr   <= sr_next;
            bcnt <= (bcnt == BCNT_LAST) ? '0 : bcnt + BW'(1);
        end
    end

    // Holding register: a load beats a same-edge take; clr leaves it untouched
    always_ff @(posedge I1294 or negedge I1300) begin
        if (!I1300) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (word_done && (!word_valid || word_ready)) begin
                word_out   <= sr_next;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            if (clr) begin
                overflow <= 1'b0;
            end else if (word_done && word_valid && !word_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_test_i1914_capture.sv
module tb_test_i1914_capture;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       bit_en;
    logic       clr;
    logic [7:0] word_out;
    logic       word_valid;
    logic       word_ready;
    logic       match;
    logic [3:0] match_cnt;
    logic       alarm;
    logic       overflow;

    int checks;
    int failures;

    test_i1914_capture #(
        .W(8),
        .PATTERN(8'hA5),
        .MATCH_LIMIT(3)
    ) dut (
        .I1294(clk),
        .I1300(rst_n),
        .I1914(din),
        .bit_en(bit_en),
        .clr(clr),
        .word_out(word_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .match(match),
        .match_cnt(match_cnt),
        .alarm(alarm),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one clock edge, outputs sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din    = b;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
    endtask

    task automatic apply_reset();
        bit_en     = 1'b0;
        clr        = 1'b0;
        din        = 1'b0;
        word_ready = 1'b0;
        rst_n      = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bit_en = 1'b0; clr = 1'b0; din = 1'b0; word_ready = 1'b0;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({word_out, word_valid, match, match_cnt, alarm, overflow} !== 16'h0) begin
            $display("FAIL reset_outputs: got %h expected 0000",
                     {word_out, word_valid, match, match_cnt, alarm, overflow});
            failures++;
        end
        apply_reset();
        checks++;
        if ({word_out, word_valid, match, match_cnt, alarm, overflow} !== 16'h0) begin
            $display("FAIL reset_release: got %h expected 0000",
                     {word_out, word_valid, match, match_cnt, alarm, overflow});
            failures++;
        end
    endtask

    task automatic test_stream();
        logic [15:0] s;
        s = 16'hA5C3;
        apply_reset();
        word_ready = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            send_bit(s[i]);
            if (i == 9) begin
                checks++;
                if (word_valid !== 1'b0) begin
                    $display("FAIL stream_bit7_valid: got %b expected 0", word_valid);
                    failures++;
                end
            end
            if (i == 8) begin
                checks++;
                if (word_valid !== 1'b1 || word_out !== 8'hA5 || match !== 1'b1) begin
                    $display("FAIL stream_word1: valid=%b word=%h match=%b expected 1 a5 1",
                             word_valid, word_out, match);
                    failures++;
                end
            end
            if (i == 7) begin
                checks++;
                if (word_valid !== 1'b0 || match !== 1'b0) begin
                    $display("FAIL stream_bit9: valid=%b match=%b expected 0 0", word_valid, match);
                    failures++;
                end
            end
        end
        checks++;
        if (word_valid !== 1'b1 || word_out !== 8'hC3 || match_cnt !== 4'd1 ||
            overflow !== 1'b0 || match !== 1'b0) begin
            $display("FAIL stream_word2: valid=%b word=%h cnt=%0d ovf=%b match=%b expected 1 c3 1 0 0",
                     word_valid, word_out, match_cnt, overflow, match);
            failures++;
        end
    endtask

    task automatic test_overflow();
        logic [23:0] s;
        s = 24'hA5C33C;
        apply_reset();
        word_ready = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            send_bit(s[i]);
            if (i == 8) begin
                checks++;
                if (word_valid !== 1'b1 || word_out !== 8'hA5 || overflow !== 1'b1) begin
                    $display("FAIL ovf_bit16: valid=%b word=%h ovf=%b expected 1 a5 1",
                             word_valid, word_out, overflow);
                    failures++;
                end
            end
        end
        checks++;
        if (word_out !== 8'hA5 || overflow !== 1'b1 || match_cnt !== 4'd1) begin
            $display("FAIL ovf_bit24: word=%h ovf=%b cnt=%0d expected a5 1 1",
                     word_out, overflow, match_cnt);
            failures++;
        end
        word_ready = 1'b1;
        tick();
        checks++;
        if (word_valid !== 1'b0 || word_out !== 8'hA5) begin
            $display("FAIL ovf_take: valid=%b word=%h expected 0 a5", word_valid, word_out);
            failures++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        s = 16'hA53C;
        apply_reset();
        word_ready = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (i == 0) word_ready = 1'b1;
            send_bit(s[i]);
            if (i < 8 && i > 0) begin
                checks++;
                if (word_valid !== 1'b1) begin
                    $display("FAIL b2b_hold: valid=%b expected 1", word_valid);
                    failures++;
                end
            end
        end
        checks++;
        if (word_valid !== 1'b1 || word_out !== 8'h3C || overflow !== 1'b0) begin
            $display("FAIL b2b_load: valid=%b word=%h ovf=%b expected 1 3c 0",
                     word_valid, word_out, overflow);
            failures++;
        end
        tick();
        checks++;
        if (word_valid !== 1'b0) begin
            $display("FAIL b2b_take: valid=%b expected 0", word_valid);
            failures++;
        end
        word_ready = 1'b0;
    endtask

    task automatic test_alarm();
        logic [7:0] p;
        p = 8'hA5;
        apply_reset();
        word_ready = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(p[i]);
                if (n == 3 && i == 1) begin
                    checks++;
                    if (alarm !== 1'b0 || match_cnt !== 4'd2) begin
                        $display("FAIL alarm_bit23: alarm=%b cnt=%0d expected 0 2", alarm, match_cnt);
                        failures++;
                    end
                end
            end
            checks++;
            if (match !== 1'b1 || match_cnt !== 4'(n) || alarm !== (n >= 3)) begin
                $display("FAIL alarm_word%0d: match=%b cnt=%0d alarm=%b expected 1 %0d %b",
                         n, match, match_cnt, alarm, n, (n >= 3));
                failures++;
            end
        end
        tick();
        checks++;
        if (match !== 1'b0 || alarm !== 1'b1 || match_cnt !== 4'd4) begin
            $display("FAIL alarm_sticky: match=%b alarm=%b cnt=%0d expected 0 1 4",
                     match, alarm, match_cnt);
            failures++;
        end
    endtask

    task automatic test_clr();
        logic [7:0] p;
        p = 8'hA5;
        apply_reset();
        word_ready = 1'b0;
        for (int n = 0; n < 3; n++)
            for (int i = 7; i >= 0; i--) send_bit(p[i]);
        checks++;
        if (alarm !== 1'b1 || overflow !== 1'b1 || word_valid !== 1'b1) begin
            $display("FAIL clr_setup: alarm=%b ovf=%b valid=%b expected 1 1 1",
                     alarm, overflow, word_valid);
            failures++;
        end
        clr = 1'b1; bit_en = 1'b1; din = 1'b1;
        tick();
        clr = 1'b0; bit_en = 1'b0;
        checks++;
        if (alarm !== 1'b0 || match_cnt !== 4'd0 || overflow !== 1'b0 ||
            word_valid !== 1'b1 || word_out !== 8'hA5) begin
            $display("FAIL clr_effect: alarm=%b cnt=%0d ovf=%b valid=%b word=%h expected 0 0 0 1 a5",
                     alarm, match_cnt, overflow, word_valid, word_out);
            failures++;
        end
        for (int i = 7; i >= 0; i--) begin
            send_bit(p[i]);
            if (i == 1) begin
                checks++;
                if (match !== 1'b0 || match_cnt !== 4'd0) begin
                    $display("FAIL clr_early: match=%b cnt=%0d expected 0 0", match, match_cnt);
                    failures++;
                end
            end
        end
        checks++;
        if (match !== 1'b1 || match_cnt !== 4'd1 || alarm !== 1'b0) begin
            $display("FAIL clr_rematch: match=%b cnt=%0d alarm=%b expected 1 1 0",
                     match, match_cnt, alarm);
            failures++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] p;
        int words;
        int hits;
        p = 8'hA5;
        words = 0;
        hits = 0;
        apply_reset();
        word_ready = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (word_valid !== 1'b0 || match_cnt !== 4'd0 || word_out !== 8'h00) begin
            $display("FAIL rstmid_async: valid=%b cnt=%0d word=%h expected 0 0 00",
                     word_valid, match_cnt, word_out);
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            send_bit(p[i]);
            if (word_valid === 1'b1) words++;
            if (match === 1'b1) hits++;
        end
        checks++;
        if (words !== 1 || hits !== 1 || word_out !== 8'hA5) begin
            $display("FAIL rstmid_word: words=%0d hits=%0d word=%h expected 1 1 a5",
                     words, hits, word_out);
            failures++;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        test_reset();
        test_stream();
        test_overflow();
        test_back_to_back();
        test_alarm();
        test_clr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
